// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_seq_pkg
// Brief    : Shared PC constants, FSM state and redirect-kind encodings.
// Revision : 1.0
// ============================================================================
package pc_seq_pkg;

    localparam logic [31:0] C_START_ADDR   = 32'h0000_3000;
    localparam logic [31:0] C_HANDLER_ADDR = 32'h0000_4180;
    localparam logic [31:0] C_PC_STEP      = 32'd4;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } pc_state_t;

    // Numeric order is the priority order; HOLD replacement relies on '>'.
    typedef enum logic [2:0] {
        RK_NONE   = 3'd0,
        RK_BRANCH = 3'd1,
        RK_JUMP   = 3'd2,
        RK_ERET   = 3'd3,
        RK_EXC    = 3'd4
    } redir_kind_t;

    function automatic logic [31:0] pc_incr(input logic [31:0] pc);
        return pc + C_PC_STEP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_seq_if
// Brief    : Control/redirect bundle between pipeline and the PC sequencer.
// Revision : 1.0
// ============================================================================
interface pc_seq_if;

    logic [31:0] curr_pc;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        exc_req;
    logic        eret;
    logic [31:0] next_pc;
    logic        pc_enable;
    logic        flush;
    logic [31:0] epc;
    logic        pending;

    modport master (
        output curr_pc, stall, br_taken, br_target, jump, jump_target, exc_req, eret,
        input  next_pc, pc_enable, flush, epc, pending
    );

    modport slave (
        input  curr_pc, stall, br_taken, br_target, jump, jump_target, exc_req, eret,
        output next_pc, pc_enable, flush, epc, pending
    );

endinterface
`default_nettype wire

// File: rtl/pc_redirect_prio.sv
`default_nettype none
// ============================================================================
// Module   : pc_redirect_prio
// Brief    : Combinational redirect priority select with misalignment check.
// Revision : 1.0
// ============================================================================
module pc_redirect_prio
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = C_HANDLER_ADDR
) (
    input  wire logic [31:0] curr_pc,
    input  wire logic        br_taken,
    input  wire logic [31:0] br_target,
    input  wire logic        jump,
    input  wire logic [31:0] jump_target,
    input  wire logic        exc_req,
    input  wire logic        eret,
    input  wire logic [31:0] epc,
    output redir_kind_t      kind,
    output logic [31:0]      target
);

    logic        w_jb_valid;
    logic [31:0] w_jb_target;
    logic        w_misaligned;

    // Only the jump/branch target that would actually win is checked.
    assign w_jb_valid   = jump | br_taken;
    assign w_jb_target  = jump ? jump_target : br_target;
    assign w_misaligned = w_jb_valid & (w_jb_target[1:0] != 2'b00);

    always_comb begin
        kind   = RK_NONE;
        target = pc_incr(curr_pc);
        if (exc_req || w_misaligned) begin
            kind   = RK_EXC;
            target = HANDLER_ADDR;
        end else if (eret) begin
            kind   = RK_ERET;
            target = epc;
        end else if (jump) begin
            kind   = RK_JUMP;
            target = jump_target;
        end else if (br_taken) begin
            kind   = RK_BRANCH;
            target = br_target;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_seq.sv
`default_nettype none
// ============================================================================
// Module   : pc_seq
// Brief    : Next-PC sequencer with stall-held redirects and exception entry.
// Revision : 1.0
// ============================================================================
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] START_ADDR   = C_START_ADDR,
    parameter logic [31:0] HANDLER_ADDR = C_HANDLER_ADDR
) (
    input  wire logic clk,
    input  wire logic rst,
    pc_seq_if.slave   bus
);

    pc_state_t   r_state,       w_state_next;
    redir_kind_t r_held_kind,   w_held_kind_next;
    logic [31:0] r_held_target, w_held_target_next;
    logic [31:0] r_epc;
    logic        w_epc_load;
    redir_kind_t w_kind;
    logic [31:0] w_target;
    logic [31:0] w_next_pc;
    logic        w_pc_enable;
    logic        w_flush;

    pc_redirect_prio #(
        .HANDLER_ADDR (HANDLER_ADDR)
    ) u_prio (
        .curr_pc     (bus.curr_pc),
        .br_taken    (bus.br_taken),
        .br_target   (bus.br_target),
        .jump        (bus.jump),
        .jump_target (bus.jump_target),
        .exc_req     (bus.exc_req),
        .eret        (bus.eret),
        .epc         (r_epc),
        .kind        (w_kind),
        .target      (w_target)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_held_kind   <= RK_NONE;
            r_held_target <= '0;
            r_epc         <= '0;
        end else begin
            r_state       <= w_state_next;
            r_held_kind   <= w_held_kind_next;
            r_held_target <= w_held_target_next;
            if (w_epc_load) begin
                r_epc <= bus.curr_pc;
            end
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_held_kind_next   = r_held_kind;
        w_held_target_next = r_held_target;
        w_epc_load         = 1'b0;
        w_next_pc          = pc_incr(bus.curr_pc);
        w_pc_enable        = 1'b0;
        w_flush            = 1'b0;

        if (rst) begin
            w_state_next = ST_RUN;
            w_next_pc    = START_ADDR;
        end else if (w_kind == RK_EXC) begin
            // Exceptions bypass stall and drop anything being held.
            w_state_next     = ST_RUN;
            w_held_kind_next = RK_NONE;
            w_epc_load       = 1'b1;
            w_next_pc        = w_target;
            w_pc_enable      = 1'b1;
            w_flush          = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!bus.stall) begin
                        w_next_pc   = w_target;
                        w_pc_enable = 1'b1;
                        w_flush     = (w_kind == RK_ERET);
                    end else if (w_kind != RK_NONE) begin
                        w_state_next       = ST_HOLD;
                        w_held_kind_next   = w_kind;
                        w_held_target_next = w_target;
                    end
                end
                ST_HOLD: begin
                    if (bus.stall) begin
                        w_next_pc = r_held_target;
                        if (w_kind > r_held_kind) begin
                            w_held_kind_next   = w_kind;
                            w_held_target_next = w_target;
                        end
                    end else begin
                        w_state_next     = ST_RUN;
                        w_held_kind_next = RK_NONE;
                        w_next_pc        = r_held_target;
                        w_pc_enable      = 1'b1;
                        w_flush          = (r_held_kind == RK_ERET);
                    end
                end
                default: begin
                    w_state_next = ST_RUN;
                end
            endcase
        end
    end

    // Pending covers the latching cycle too, and drops in the release cycle.
    assign bus.next_pc   = w_next_pc;
    assign bus.pc_enable = w_pc_enable;
    assign bus.flush     = w_flush;
    assign bus.epc       = r_epc;
    assign bus.pending   = (w_state_next == ST_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_pc_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_seq
// Brief    : Directed plus randomized self-checking bench for pc_seq.
// Revision : 1.0
// ============================================================================
module tb_pc_seq;

    localparam logic [31:0] START   = 32'h0000_3000;
    localparam logic [31:0] HANDLER = 32'h0000_4180;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_seq_if bus();

    pc_seq #(
        .START_ADDR   (START),
        .HANDLER_ADDR (HANDLER)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: at most one outstanding redirect, ranked 1..3.
    bit          m_hold   = 1'b0;
    logic [31:0] m_target = '0;
    int          m_rank   = 0;
    bit          m_eret   = 1'b0;
    logic [31:0] m_epc    = '0;

    logic [31:0] s_next, s_epc;
    logic        s_en, s_fl, s_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] pc, input logic st, input logic br,
                          input logic [31:0] brt, input logic j, input logic [31:0] jt,
                          input logic exc, input logic er);
        bus.curr_pc     = pc;
        bus.stall       = st;
        bus.br_taken    = br;
        bus.br_target   = brt;
        bus.jump        = j;
        bus.jump_target = jt;
        bus.exc_req     = exc;
        bus.eret        = er;
    endtask

    // Inputs are stable from just after a rising edge; outputs sampled at the falling edge.
    task automatic step(input string tag);
        logic [31:0] e_next, jb, seq, cand_tgt;
        logic        e_en, e_fl, e_pend, chk_next;
        int          cand_rank;
        bit          n_hold, n_eret;
        logic [31:0] n_target, n_epc;
        int          n_rank;

        chk_next = 1'b1;
        e_next = '0; e_en = 1'b0; e_fl = 1'b0; e_pend = 1'b0;
        n_hold = m_hold; n_target = m_target; n_rank = m_rank; n_eret = m_eret; n_epc = m_epc;
        jb  = bus.jump ? bus.jump_target : bus.br_target;
        seq = 32'((64'(bus.curr_pc) + 64'd4) % 64'h1_0000_0000);

        if (rst) begin
            e_next = START;
            n_hold = 1'b0; n_target = '0; n_rank = 0; n_eret = 1'b0; n_epc = '0;
        end else if (bus.exc_req || ((bus.jump || bus.br_taken) && (jb % 4 != 0))) begin
            e_next = HANDLER; e_en = 1'b1; e_fl = 1'b1;
            n_epc = bus.curr_pc; n_hold = 1'b0;
        end else begin
            cand_rank = bus.eret ? 3 : bus.jump ? 2 : bus.br_taken ? 1 : 0;
            cand_tgt  = bus.eret ? m_epc : bus.jump ? bus.jump_target :
                        bus.br_taken ? bus.br_target : seq;
            if (!m_hold && !bus.stall) begin
                e_next = cand_tgt; e_en = 1'b1; e_fl = bus.eret;
            end else if (!m_hold) begin
                if (cand_rank == 0) begin
                    e_next = seq;
                end else begin
                    chk_next = 1'b0; e_pend = 1'b1;
                    n_hold = 1'b1; n_target = cand_tgt; n_rank = cand_rank; n_eret = bus.eret;
                end
            end else if (bus.stall) begin
                chk_next = 1'b0; e_pend = 1'b1;
                if (cand_rank > m_rank) begin
                    n_target = cand_tgt; n_rank = cand_rank; n_eret = bus.eret;
                end
            end else begin
                e_next = m_target; e_en = 1'b1; e_fl = m_eret; n_hold = 1'b0;
            end
        end

        @(negedge clk);
        s_next = bus.next_pc; s_en = bus.pc_enable; s_fl = bus.flush; s_pend = bus.pending;
        if (chk_next) chk({tag, ".next_pc"}, s_next, e_next);
        chk({tag, ".pc_enable"}, 32'(s_en),   32'(e_en));
        chk({tag, ".flush"},     32'(s_fl),   32'(e_fl));
        chk({tag, ".pending"},   32'(s_pend), 32'(e_pend));

        @(posedge clk);
        #1;
        m_hold = n_hold; m_target = n_target; m_rank = n_rank; m_eret = n_eret; m_epc = n_epc;
        s_epc = bus.epc;
        chk({tag, ".epc"}, s_epc, m_epc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] tj, tb;
        set_in('0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        step("reset");
        chk("reset.next_pc", s_next, START);
        chk("reset.pc_enable", 32'(s_en), 32'd0);
        chk("reset.epc", s_epc, 32'd0);

        rst = 1'b0;
        set_in(32'h3000, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        step("seq");
        chk("seq.next_pc", s_next, 32'h3004);
        chk("seq.pc_enable", 32'(s_en), 32'd1);

        for (int i = 0; i < 3; i++) begin
            set_in(32'h3004, 1'b1, 1'b1, 32'h3100, 1'b0, '0, 1'b0, 1'b0);
            step("stall_br");
            chk("stall_br.pending", 32'(s_pend), 32'd1);
            chk("stall_br.pc_enable", 32'(s_en), 32'd0);
        end
        set_in(32'h3004, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        step("rel_br");
        chk("rel_br.next_pc", s_next, 32'h3100);
        chk("rel_br.pending", 32'(s_pend), 32'd0);

        set_in(32'h3010, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        step("exc");
        chk("exc.next_pc", s_next, HANDLER);
        chk("exc.flush", 32'(s_fl), 32'd1);
        chk("exc.epc", s_epc, 32'h3010);

        set_in(HANDLER, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        step("eret");
        chk("eret.next_pc", s_next, 32'h3010);
        chk("eret.flush", 32'(s_fl), 32'd1);
        set_in(32'h3010, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        step("post_eret");
        chk("post_eret.flush", 32'(s_fl), 32'd0);

        set_in(32'h3020, 1'b0, 1'b0, '0, 1'b1, 32'h3102, 1'b0, 1'b0);
        step("misal");
        chk("misal.next_pc", s_next, HANDLER);
        chk("misal.epc", s_epc, 32'h3020);

        set_in(HANDLER, 1'b0, 1'b1, 32'h3300, 1'b1, 32'h3200, 1'b0, 1'b0);
        step("jmp_br");
        chk("jmp_br.next_pc", s_next, 32'h3200);
        chk("jmp_br.flush", 32'(s_fl), 32'd0);

        set_in(32'h3200, 1'b1, 1'b1, 32'h3400, 1'b0, '0, 1'b0, 1'b0);
        step("hold_br");
        set_in(32'h3200, 1'b1, 1'b0, '0, 1'b1, 32'h3500, 1'b0, 1'b0);
        step("hold_up");
        set_in(32'h3200, 1'b1, 1'b1, 32'h3600, 1'b0, '0, 1'b0, 1'b0);
        step("hold_low");
        set_in(32'h3200, 1'b0, 1'b1, 32'h3700, 1'b0, '0, 1'b0, 1'b0);
        step("hold_rel");
        chk("hold_rel.next_pc", s_next, 32'h3500);

        set_in(32'hFFFF_FFFC, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        step("wrap");
        chk("wrap.next_pc", s_next, 32'h0000_0000);

        set_in(32'h3000, 1'b1, 1'b0, '0, 1'b1, 32'h3800, 1'b0, 1'b0);
        step("hold_j");
        chk("hold_j.pending", 32'(s_pend), 32'd1);
        rst = 1'b1;
        step("rst_hold");
        chk("rst_hold.pending", 32'(s_pend), 32'd0);
        chk("rst_hold.next_pc", s_next, START);
        chk("rst_hold.pc_enable", 32'(s_en), 32'd0);
        rst = 1'b0;
        set_in(32'h3000, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        step("after_rst");
        chk("after_rst.next_pc", s_next, 32'h3004);

        for (int n = 0; n < 400; n++) begin
            tj = $urandom & 32'hFFFF_FFFC;
            tb = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) tj[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) tb[1:0] = 2'($urandom_range(1, 3));
            rst = ($urandom_range(0, 49) == 0);
            set_in(($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC),
                   1'($urandom_range(0, 1)),
                   ($urandom_range(0, 4) == 0), tb,
                   ($urandom_range(0, 5) == 0), tj,
                   ($urandom_range(0, 15) == 0),
                   ($urandom_range(0, 7) == 0));
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
